// File: rtl/cop_dispatch.sv
// -----------------------------------------------------------------------------
// cop_dispatch
//
// Decode-stage dispatch controller for the GCD/LCM coprocessor instructions
// (opcode 7'b0000000 = gcd, 7'b0000001 = lcm). While such an instruction is in
// flight the core is stalled. The operands go to the coprocessor over a
// valid/ready handshake, and the controller waits for the result strobe under
// a bounded timeout. The result is then written back through a dedicated
// register-file write port. If either operand is zero, the result is formed
// locally and the coprocessor is never issued to.
//
// Parameters
//   XLEN     operand/result width
//   TIMEOUT  max cycles spent in WAIT before Fault; 0 disables the timeout
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   InstrValid, Op        decode-stage instruction valid / opcode
//   SrcA, SrcB, Rd        register operands (unsigned) / destination register
//   Stall                 hold fetch/decode (the only combinational output)
//   CopValid, CopReady    issue handshake
//   CopFunc, CopA, CopB   registered request payload (func 0 = gcd, 1 = lcm)
//   CopDone, CopResult    single-cycle completion strobe and its result
//   CopWE, CopRd, CopWD   register-file writeback port
//   Busy                  controller is not idle
//   Fault                 one-cycle pulse when WAIT times out
// -----------------------------------------------------------------------------
module cop_dispatch #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            InstrValid,
    input  logic [6:0]      Op,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [4:0]      Rd,
    output logic            Stall,
    output logic            CopValid,
    input  logic            CopReady,
    output logic            CopFunc,
    output logic [XLEN-1:0] CopA,
    output logic [XLEN-1:0] CopB,
    input  logic            CopDone,
    input  logic [XLEN-1:0] CopResult,
    output logic            CopWE,
    output logic [4:0]      CopRd,
    output logic [XLEN-1:0] CopWD,
    output logic            Busy,
    output logic            Fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    // The timer only has to reach TIMEOUT-1. The +2 keeps the width at one bit
    // or more when TIMEOUT is 0 or 1.
    localparam int unsigned  TW         = $clog2(TIMEOUT + 2);
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_start;
    logic              w_bypass;
    logic              w_timeout;
    logic              w_stall;
    logic              w_wb_rd_nz;

    logic              r_func;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_wd;
    logic [TW-1:0]     r_timer;
    logic              r_cop_valid;
    logic              r_cop_we;
    logic              r_fault;
    logic              r_busy;

    assign w_start   = InstrValid && ((Op == 7'b0000000) || (Op == 7'b0000001));
    assign w_bypass  = (SrcA == '0) || (SrcB == '0);
    assign w_timeout = (TIMEOUT != 0) && (r_timer == TIMER_LAST);

    // On the bypass path WB is entered straight from IDLE, before Rd has been
    // latched, so the write enable has to look at the live Rd in that case.
    assign w_wb_rd_nz = (r_state == S_IDLE) ? (Rd != 5'd0) : (r_rd != 5'd0);

    // NOTE: every signal written here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_stall      = 1'b1;
                    w_next_state = w_bypass ? S_WB : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_stall = 1'b1;
                if (CopReady) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                // A completion in the last allowed cycle wins over the timeout.
                if (CopDone) begin
                    w_next_state = S_WB;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                end
            end
            S_WB: begin
                // Stall is low here, so the instruction retires. A start
                // presented now is looked at again in IDLE on the next cycle.
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values no matter what order the statements are in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_func      <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_rd        <= '0;
            r_wd        <= '0;
            r_timer     <= '0;
            r_cop_valid <= 1'b0;
            r_cop_we    <= 1'b0;
            r_fault     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (r_state == S_IDLE && w_start) begin
                r_func <= Op[0];
                r_a    <= SrcA;
                r_b    <= SrcB;
                r_rd   <= Rd;
                // Zero operand: gcd(x,0) = x and lcm(x,0) = 0, so gcd is just
                // the OR of the two operands.
                if (w_bypass) begin
                    r_wd <= Op[0] ? '0 : (SrcA | SrcB);
                end
            end

            if (r_state == S_WAIT && CopDone) begin
                r_wd <= CopResult;
            end

            // The timer is held at zero throughout ISSUE, so it reads zero on
            // the first WAIT cycle.
            if (r_state == S_ISSUE) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT) begin
                r_timer <= r_timer + 1'b1;
            end

            // Each registered output is computed from the state being entered,
            // so it lines up with that state.
            r_cop_valid <= (w_next_state == S_ISSUE);
            r_cop_we    <= (w_next_state == S_WB) && w_wb_rd_nz;
            r_fault     <= (r_state == S_WAIT) && !CopDone && w_timeout;
            r_busy      <= (w_next_state != S_IDLE);
        end
    end

    assign Stall    = w_stall;
    assign CopValid = r_cop_valid;
    assign CopFunc  = r_func;
    assign CopA     = r_a;
    assign CopB     = r_b;
    assign CopWE    = r_cop_we;
    assign CopRd    = r_rd;
    assign CopWD    = r_wd;
    assign Busy     = r_busy;
    assign Fault    = r_fault;

endmodule

// File: tb/tb_cop_dispatch.sv
// -----------------------------------------------------------------------------
// tb_cop_dispatch
//
// Self-checking bench for cop_dispatch (XLEN=32, TIMEOUT=8). The bench acts as
// both the decode stage and the coprocessor. Each instruction is described as
// a transaction: operands, destination, handshake delay and completion delay.
// From that description the bench works out the cycle-by-cycle outputs. Gcd
// and lcm come from plain arithmetic, and the zero-operand result comes from
// the bypass rule. Unrelated inputs are randomised throughout.
// -----------------------------------------------------------------------------
module tb_cop_dispatch;

    localparam int unsigned XLEN = 32;
    localparam int          T    = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            InstrValid;
    logic [6:0]      Op;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic [4:0]      Rd;
    logic            Stall;
    logic            CopValid;
    logic            CopReady;
    logic            CopFunc;
    logic [XLEN-1:0] CopA;
    logic [XLEN-1:0] CopB;
    logic            CopDone;
    logic [XLEN-1:0] CopResult;
    logic            CopWE;
    logic [4:0]      CopRd;
    logic [XLEN-1:0] CopWD;
    logic            Busy;
    logic            Fault;

    int n_checks = 0;
    int n_fail   = 0;

    cop_dispatch #(.XLEN(XLEN), .TIMEOUT(T)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .InstrValid (InstrValid),
        .Op         (Op),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .Rd         (Rd),
        .Stall      (Stall),
        .CopValid   (CopValid),
        .CopReady   (CopReady),
        .CopFunc    (CopFunc),
        .CopA       (CopA),
        .CopB       (CopB),
        .CopDone    (CopDone),
        .CopResult  (CopResult),
        .CopWE      (CopWE),
        .CopRd      (CopRd),
        .CopWD      (CopWD),
        .Busy       (Busy),
        .Fault      (Fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic st, input logic bu,
                              input logic va, input logic we, input logic fa);
        check({tag, ".stall"}, 32'(Stall),    32'(st));
        check({tag, ".busy"},  32'(Busy),     32'(bu));
        check({tag, ".valid"}, 32'(CopValid), 32'(va));
        check({tag, ".we"},    32'(CopWE),    32'(we));
        check({tag, ".fault"}, 32'(Fault),    32'(fa));
    endtask

    // Reference coprocessor arithmetic.
    function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x = a;
        logic [31:0] y = b;
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [31:0] ref_cop(input logic func, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (!func) return ref_gcd(a, b);
        p = 64'(a / ref_gcd(a, b)) * 64'(b);
        return p[31:0];
    endfunction

    // Background decode/coprocessor traffic. It never forms a new start unless
    // allow_custom is set.
    task automatic noise(input logic allow_custom);
        InstrValid = 1'($urandom_range(0, 1));
        Op         = allow_custom ? 7'($urandom_range(0, 127)) : 7'($urandom_range(2, 127));
        SrcA       = $urandom;
        SrcB       = $urandom;
        Rd         = 5'($urandom_range(0, 31));
        CopReady   = 1'($urandom_range(0, 1));
        CopDone    = ($urandom_range(0, 3) == 0);
        CopResult  = $urandom;
    endtask

    // One custom instruction. done_dly counts WAIT cycles from entry (0-based).
    // A value of T or more means the coprocessor never answers.
    task automatic run_txn(input string name, input logic func, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd,
                           input int rdy_dly, input int done_dly);
        logic [31:0] exp_wd;
        logic        timed_out;
        int          n_wait;
        @(negedge clk);
        noise(1'b0);
        InstrValid = 1'b1;
        Op         = {6'd0, func};
        SrcA       = a;
        SrcB       = b;
        Rd         = rd;
        #1 check_ctrl({name, ".start"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        if (a == 0 || b == 0) begin
            exp_wd = func ? 32'd0 : (a | b);
        end else begin
            for (int i = 0; i <= rdy_dly; i++) begin
                @(negedge clk);
                noise(1'b1);
                CopReady = (i == rdy_dly);
                #1 check_ctrl({name, ".issue"}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
                check({name, ".cop_a"},    CopA,          a);
                check({name, ".cop_b"},    CopB,          b);
                check({name, ".cop_func"}, 32'(CopFunc),  32'(func));
            end
            timed_out = (done_dly >= T);
            n_wait    = timed_out ? T : done_dly + 1;
            exp_wd    = ref_cop(func, a, b);
            for (int j = 0; j < n_wait; j++) begin
                @(negedge clk);
                noise(1'b1);
                CopDone   = !timed_out && (j == done_dly);
                CopResult = CopDone ? exp_wd : $urandom;
                #1 check_ctrl({name, ".wait"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            end
            if (timed_out) begin
                @(negedge clk);
                noise(1'b0);
                #1 check_ctrl({name, ".fault"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                @(negedge clk);
                noise(1'b0);
                #1 check_ctrl({name, ".post_fault"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
        end
        @(negedge clk);
        noise(1'b1);
        #1 check_ctrl({name, ".wb"}, 1'b0, 1'b1, 1'b0, (rd != 5'd0), 1'b0);
        if (rd != 5'd0) begin
            check({name, ".wb_rd"}, 32'(CopRd), 32'(rd));
            check({name, ".wb_wd"}, CopWD,      exp_wd);
        end
        @(negedge clk);
        noise(1'b0);
        #1 check_ctrl({name, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_ctrl(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, ".cop_a"},    CopA,         32'd0);
        check({tag, ".cop_b"},    CopB,         32'd0);
        check({tag, ".cop_func"}, 32'(CopFunc), 32'd0);
        check({tag, ".cop_rd"},   32'(CopRd),   32'd0);
        check({tag, ".cop_wd"},   CopWD,        32'd0);
    endtask

    // Reset is applied in the middle of WAIT, and a stray completion follows
    // once reset is released.
    task automatic run_reset_in_wait();
        @(negedge clk);
        noise(1'b0);
        InstrValid = 1'b1;
        Op         = 7'd0;
        SrcA       = 32'd12;
        SrcB       = 32'd8;
        Rd         = 5'd9;
        #1 check_ctrl("rst.start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        noise(1'b1);
        CopReady = 1'b1;
        #1 check_ctrl("rst.issue", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            noise(1'b1);
            CopDone = 1'b0;
            #1 check_ctrl("rst.wait", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        InstrValid = 1'b0;
        CopDone    = 1'b0;
        reset_n    = 1'b0;
        #1 check_all_zero("rst.async");
        @(negedge clk);
        reset_n    = 1'b1;
        InstrValid = 1'b0;
        CopDone    = 1'b1;
        CopResult  = 32'hdead_beef;
        #1 check_all_zero("rst.release");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            noise(1'b0);
            CopDone = 1'b1;
            #1 check_ctrl("rst.stray_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        func;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;

        reset_n    = 1'b0;
        InstrValid = 1'b0;
        Op         = 7'd0;
        SrcA       = '0;
        SrcB       = '0;
        Rd         = '0;
        CopReady   = 1'b0;
        CopDone    = 1'b0;
        CopResult  = '0;
        #12 check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        #1 check_all_zero("reset.release");

        // Scenarios from the design's test plan.
        run_txn("gcd_basic",   1'b0, 32'd48, 32'd18, 5'd5, 0, 2);
        run_txn("lcm_bypass",  1'b1, 32'd0,  32'd7,  5'd3, 0, 0);
        run_txn("gcd_bypass",  1'b0, 32'd0,  32'd7,  5'd3, 0, 0);
        run_txn("gcd_bypassb", 1'b0, 32'd9,  32'd0,  5'd4, 0, 0);
        run_txn("backpress",   1'b1, 32'd6,  32'd10, 5'd7, 5, 1);
        run_txn("timeout",     1'b0, 32'd30, 32'd45, 5'd8, 0, T + 3);
        run_txn("done_last",   1'b1, 32'd4,  32'd6,  5'd8, 2, T - 1);
        run_txn("rd_zero",     1'b0, 32'd12, 32'd8,  5'd0, 1, 0);
        run_reset_in_wait();

        for (int n = 0; n < 40; n++) begin
            func = 1'($urandom_range(0, 1));
            a    = ($urandom_range(0, 4) == 0) ? 32'd0 :
                   ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(1, 5000));
            b    = ($urandom_range(0, 4) == 0) ? 32'd0 :
                   ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(1, 5000));
            rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            run_txn("rand", func, a, b, rd, int'($urandom_range(0, 4)),
                    int'($urandom_range(0, T + 1)));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(negedge clk);
                noise(1'b0);
                #1 check_ctrl("rand.gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
